// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and line levels
// Used by the transmitter now and by the receiver in its next revision.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;

  // Counter width helper: never returns less than one bit.
  function automatic int uart_cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - parallel request side and serial line of the UART transmitter
// master = command logic driving requests, slave = the transmitter.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] data_in;
  logic                 send;
  logic                 tx;
  logic                 busy;
  logic                 done;

  modport master (
    output data_in,
    output send,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  data_in,
    input  send,
    output tx,
    output busy,
    output done
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter, ticks on the last clock of each bit
// With CLKS_PER_BIT=1 the count is constant zero and every cycle ticks.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_bit_tick
);

  localparam int            CW   = uart_cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_bit_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start bit, MSB-first data, stop bit(s)
// Every output is a register; tx is loaded with the level of the state being entered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   bus
);

  localparam int             BCW       = uart_cnt_width(DATA_BITS + 1);
  localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

  uart_state_e          r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [BCW-1:0]       r_bit_cnt;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_bit_tick;
  logic                 w_baud_clear;
  logic [DATA_BITS-1:0] w_shift_next;

  // The baud counter idles at zero so each frame starts on a fresh bit period.
  assign w_baud_clear = (r_state == IDLE);
  assign w_shift_next = r_shift << 1;

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_baud_clear),
    .o_bit_tick (w_bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_tx      <= UART_IDLE_LVL;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tx   <= UART_IDLE_LVL;
          r_busy <= 1'b0;
          if (bus.send) begin
            r_shift   <= bus.data_in;
            r_bit_cnt <= '0;
            r_tx      <= UART_START_LVL;
            r_busy    <= 1'b1;
            r_state   <= START;
          end
        end
        START: begin
          if (w_bit_tick) begin
            r_bit_cnt <= '0;
            r_tx      <= r_shift[DATA_BITS-1];
            r_state   <= DATA;
          end
        end
        DATA: begin
          if (w_bit_tick) begin
            r_shift <= w_shift_next;
            if (r_bit_cnt == LAST_DATA) begin
              r_bit_cnt <= '0;
              r_tx      <= UART_STOP_LVL;
              r_state   <= STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + BCW'(1);
              r_tx      <= w_shift_next[DATA_BITS-1];
            end
          end
        end
        STOP: begin
          if (w_bit_tick) begin
            if (r_bit_cnt == LAST_STOP) begin
              r_bit_cnt <= '0;
              r_tx      <= UART_IDLE_LVL;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + BCW'(1);
            end
          end
        end
        default: begin
          r_tx    <= UART_IDLE_LVL;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx   = r_tx;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx
// Three configurations share one clock/reset; a line monitor deserialises the default instance.
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_if #(.DATA_BITS(8)) bus1();
  uart_tx_if #(.DATA_BITS(8)) bus4();
  uart_tx_if #(.DATA_BITS(7)) bus7();

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(1), .STOP_BITS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  uart_tx #(.DATA_BITS(7), .CLKS_PER_BIT(1), .STOP_BITS(2)) dut7 (.clk(clk), .rst(rst), .bus(bus7));

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  int         mon_phase = 0;
  int         mon_cnt   = 0;
  logic [7:0] mon_byte  = 8'h00;
  logic [7:0] mon_exp;

  // Receiver model for the default instance: first data bit lands in the MSB.
  always @(negedge clk) begin
    if (rst) begin
      mon_phase = 0;
      mon_cnt   = 0;
    end else begin
      case (mon_phase)
        0: if (bus1.tx === 1'b0) begin
          mon_phase = 1;
          mon_cnt   = 0;
        end
        1: begin
          mon_byte = {mon_byte[6:0], bus1.tx};
          mon_cnt++;
          if (mon_cnt == 8) mon_phase = 2;
        end
        default: begin
          n_tests++;
          if (bus1.tx !== 1'b1) begin
            n_fail++;
            $display("FAIL rx_stop_bit: tx=%b expected 1", bus1.tx);
          end
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rx_unexpected_frame: got %h expected no frame", mon_byte);
          end else begin
            mon_exp = exp_q.pop_front();
            if (mon_byte !== mon_exp) begin
              n_fail++;
              $display("FAIL rx_byte: got %h expected %h", mon_byte, mon_exp);
            end
          end
          mon_phase = 0;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus1.send = 1'b1; bus1.data_in = 8'hFF;
    bus4.send = 1'b1; bus4.data_in = 8'hFF;
    bus7.send = 1'b1; bus7.data_in = 7'h7F;
    tick();
    tick();
    n_tests++;
    if ({bus1.tx, bus1.busy, bus1.done} !== 3'b100) begin
      n_fail++; $display("FAIL reset_dut1: tx/busy/done=%b expected 100", {bus1.tx, bus1.busy, bus1.done});
    end
    n_tests++;
    if ({bus4.tx, bus4.busy, bus4.done} !== 3'b100) begin
      n_fail++; $display("FAIL reset_dut4: tx/busy/done=%b expected 100", {bus4.tx, bus4.busy, bus4.done});
    end
    n_tests++;
    if ({bus7.tx, bus7.busy, bus7.done} !== 3'b100) begin
      n_fail++; $display("FAIL reset_dut7: tx/busy/done=%b expected 100", {bus7.tx, bus7.busy, bus7.done});
    end
    rst = 1'b0;
    bus1.send = 1'b0;
    bus4.send = 1'b0;
    bus7.send = 1'b0;
    tick();
    n_tests++;
    if ({bus1.tx, bus1.busy} !== 2'b10) begin
      n_fail++; $display("FAIL reset_send_dropped: tx/busy=%b expected 10", {bus1.tx, bus1.busy});
    end
  endtask

  task automatic test_basic_a5();
    logic [9:0] exp;
    exp = {1'b0, 8'hA5, 1'b1};
    bus1.data_in = 8'hA5; bus1.send = 1'b1;
    exp_q.push_back(8'hA5);
    tick();
    bus1.send = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (bus1.tx !== exp[9-i]) begin
        n_fail++; $display("FAIL a5_tx[%0d]: tx=%b expected %b", i, bus1.tx, exp[9-i]);
      end
      n_tests++;
      if ({bus1.busy, bus1.done} !== 2'b10) begin
        n_fail++; $display("FAIL a5_busy[%0d]: busy/done=%b expected 10", i, {bus1.busy, bus1.done});
      end
      tick();
    end
    n_tests++;
    if ({bus1.tx, bus1.busy, bus1.done} !== 3'b101) begin
      n_fail++; $display("FAIL a5_done: tx/busy/done=%b expected 101", {bus1.tx, bus1.busy, bus1.done});
    end
    tick();
    n_tests++;
    if (bus1.done !== 1'b0) begin
      n_fail++; $display("FAIL a5_done_width: done=%b expected 0", bus1.done);
    end
  endtask

  task automatic test_cpb4_3c();
    logic [9:0] exp;
    exp = {1'b0, 8'h3C, 1'b1};
    bus4.data_in = 8'h3C; bus4.send = 1'b1;
    tick();
    bus4.send = 1'b0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 4; c++) begin
        n_tests++;
        if (bus4.tx !== exp[9-b] || bus4.busy !== 1'b1 || bus4.done !== 1'b0) begin
          n_fail++;
          $display("FAIL cpb4_bit%0d_clk%0d: tx/busy/done=%b%b%b expected %b10",
                   b, c, bus4.tx, bus4.busy, bus4.done, exp[9-b]);
        end
        tick();
      end
    end
    n_tests++;
    if ({bus4.tx, bus4.busy, bus4.done} !== 3'b101) begin
      n_fail++; $display("FAIL cpb4_done: tx/busy/done=%b expected 101", {bus4.tx, bus4.busy, bus4.done});
    end
    tick();
  endtask

  task automatic test_busy_reject();
    logic [9:0] exp;
    int         done_cnt;
    exp = {1'b0, 8'hFF, 1'b1};
    done_cnt = 0;
    bus1.data_in = 8'hFF; bus1.send = 1'b1;
    exp_q.push_back(8'hFF);
    tick();
    bus1.send = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 4) begin
        bus1.data_in = 8'h00; bus1.send = 1'b1;
      end
      if (i == 5) bus1.send = 1'b0;
      n_tests++;
      if (bus1.tx !== ((i < 10) ? exp[9-i] : 1'b1)) begin
        n_fail++; $display("FAIL reject_tx[%0d]: tx=%b expected %b", i, bus1.tx, (i < 10) ? exp[9-i] : 1'b1);
      end
      if (bus1.done === 1'b1) done_cnt++;
      tick();
    end
    n_tests++;
    if (done_cnt != 1) begin
      n_fail++; $display("FAIL reject_done_count: got %0d expected 1", done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [20:0] exp;
    exp = {1'b0, 8'h81, 1'b1, 1'b1, 1'b0, 8'h7E, 1'b1};
    bus1.data_in = 8'h81; bus1.send = 1'b1;
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h7E);
    tick();
    for (int c = 1; c <= 22; c++) begin
      if (c == 1) bus1.data_in = 8'h7E;
      if (c == 12) bus1.send = 1'b0;
      if (c <= 21) begin
        n_tests++;
        if (bus1.tx !== exp[21-c]) begin
          n_fail++; $display("FAIL b2b_tx[%0d]: tx=%b expected %b", c, bus1.tx, exp[21-c]);
        end
      end
      n_tests++;
      if (bus1.done !== ((c == 11) || (c == 22))) begin
        n_fail++; $display("FAIL b2b_done[%0d]: done=%b expected %b", c, bus1.done, (c == 11) || (c == 22));
      end
      if (c < 22) tick();
    end
    bus1.send = 1'b0;
    tick();
  endtask

  task automatic test_reset_midframe();
    logic [9:0] exp;
    bus1.data_in = 8'h55; bus1.send = 1'b1;
    tick();
    bus1.send = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_tests++;
    if (bus1.busy !== 1'b1) begin
      n_fail++; $display("FAIL midrst_inframe: busy=%b expected 1", bus1.busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({bus1.tx, bus1.busy, bus1.done} !== 3'b100) begin
      n_fail++; $display("FAIL midrst_state: tx/busy/done=%b expected 100", {bus1.tx, bus1.busy, bus1.done});
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      n_tests++;
      if ({bus1.tx, bus1.done} !== 2'b10) begin
        n_fail++; $display("FAIL midrst_quiet[%0d]: tx/done=%b expected 10", i, {bus1.tx, bus1.done});
      end
    end
    exp = {1'b0, 8'h0F, 1'b1};
    bus1.data_in = 8'h0F; bus1.send = 1'b1;
    exp_q.push_back(8'h0F);
    tick();
    bus1.send = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (bus1.tx !== exp[9-i]) begin
        n_fail++; $display("FAIL midrst_0f_tx[%0d]: tx=%b expected %b", i, bus1.tx, exp[9-i]);
      end
      tick();
    end
    n_tests++;
    if (bus1.done !== 1'b1) begin
      n_fail++; $display("FAIL midrst_0f_done: done=%b expected 1", bus1.done);
    end
    tick();
  endtask

  task automatic test_7bit_2stop();
    logic [9:0] exp;
    exp = 10'b0_1000001_11;
    bus7.data_in = 7'h41; bus7.send = 1'b1;
    tick();
    bus7.send = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (bus7.tx !== exp[9-i] || bus7.done !== 1'b0) begin
        n_fail++; $display("FAIL d7s2_tx[%0d]: tx/done=%b%b expected %b0", i, bus7.tx, bus7.done, exp[9-i]);
      end
      tick();
    end
    n_tests++;
    if ({bus7.tx, bus7.busy, bus7.done} !== 3'b101) begin
      n_fail++; $display("FAIL d7s2_done: tx/busy/done=%b expected 101", {bus7.tx, bus7.busy, bus7.done});
    end
    tick();
  endtask

  initial begin
    bus1.send = 1'b0; bus1.data_in = '0;
    bus4.send = 1'b0; bus4.data_in = '0;
    bus7.send = 1'b0; bus7.data_in = '0;
    test_reset();
    test_basic_a5();
    test_cpb4_3c();
    test_busy_reject();
    test_back_to_back();
    test_reset_midframe();
    test_7bit_2stop();
    tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL rx_missing_frames: %0d left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter; the transmit end of the on-board UART link.
- Accepts one parallel byte per request and serialises it onto a single line: start bit (0), DATA_BITS data bits MSB-first, STOP_BITS stop bits (1).
- Each bit is held for CLKS_PER_BIT clocks.
- Sits between the internal command logic and the board-level TX pin. Its frame format and bit order match the team's uartRX deserialiser: the first data bit shifts into the receiver's MSB.

Parameters:
- DATA_BITS, 8, data bits per frame (1..8).
- CLKS_PER_BIT, 1, clock cycles per serial bit (>=1). The default of 1 matches the receiver's one-sample-per-clock operation.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk      in   1          system clock; all logic on the rising edge.
- rst      in   1          reset, synchronous, active-high.
- data_in  in   DATA_BITS  byte to send; sampled only on the acceptance cycle.
- send     in   1          request; accepted when send=1 and busy=0.
- tx       out  1          serial line; idles high.
- busy     out  1          high while a frame is in flight.
- done     out  1          one-cycle pulse after the last stop bit.

Behaviour:
- Reset: rst=1 at an edge gives tx=1, busy=0, done=0, state=IDLE, bit counter=0, baud counter=0, shift register=0. Reset wins over every other condition.
- States: IDLE, START, DATA, STOP. Encoded as a 2-bit enum.
- IDLE:
  - tx=1, busy=0.
  - If send=1 at edge N: latch data_in into the shift register, clear both counters, go to START. busy=1 and tx=0 are visible from cycle N+1.
- START:
  - tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx = shift register MSB (bit DATA_BITS-1).
  - Each bit is held CLKS_PER_BIT cycles. At the end of each bit period, shift the register left by 1 and increment the bit counter.
  - After DATA_BITS bits, go to STOP.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE with done=1 for exactly that first IDLE cycle.
- Latency: first start-bit cycle = acceptance edge + 1. Frame occupies (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT cycles. done is asserted in the cycle after the final stop cycle.
- Baud counter:
  - Width = clog2(CLKS_PER_BIT) (minimum 1).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at the end of each bit period.
  - With CLKS_PER_BIT=1 it is constant 0 and every cycle is a bit boundary.
- Bit counter:
  - Width = clog2(DATA_BITS+1). Counts STOP bits as well.
  - No overflow: it is cleared on every state entry.
- send while busy=1 is ignored; no queuing, no error flag. data_in changes during a frame have no effect.
- Back-to-back frames: send=1 in the done cycle (state IDLE, busy=0) is accepted. The next start bit follows one idle-high cycle, so the minimum inter-frame gap is 1 clk.
- Simultaneous rst=1 and send=1: reset wins and the request is dropped.
- Reset mid-frame: the line returns high on the next cycle, the frame is abandoned, and no done pulse is issued.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE/START/DATA/STOP);
  - constants UART_IDLE_LVL=1, UART_START_LVL=0, UART_STOP_LVL=1.
- uartRX reuses the same package in its next revision.
- One natural sub-module: uart_baud_cnt. It is a parameterised CLKS_PER_BIT counter with clear input and bit_tick output, and is shared later with the receiver.
- FSM, shift register and bit counter stay in uart_tx.

Test Plan:
- Defaults, send=1 with data_in=8'hA5 at edge N:
  - tx over cycles N+1..N+10 = 0,1,0,1,0,0,1,0,1,1.
  - busy=1 for cycles N+1..N+10.
  - done=1 only in cycle N+11.
  - Loop back through uartRX and check received 8'hA5.
- CLKS_PER_BIT=4, data 8'h3C:
  - Each bit is held exactly 4 cycles.
  - Frame = 40 cycles.
  - done is asserted 41 cycles after acceptance.
- Busy rejection: send 8'hFF, then pulse send with data_in=8'h00 at cycle N+5.
  - Line still carries 0 then eight 1s then a stop bit.
  - Exactly one done.
- Back-to-back: hold send=1 with 8'h81 then 8'h7E.
  - Second start bit appears 1 idle-high cycle after first done.
  - Both frames bit-exact.
- Reset mid-frame: rst=1 during data bit 3 of 8'h55.
  - Next cycle tx=1, busy=0, done=0.
  - A subsequent send of 8'h0F transmits cleanly.
- STOP_BITS=2, DATA_BITS=7, data 7'h41:
  - tx = 0,1,0,0,0,0,0,1,1,1.
  - done is asserted in cycle N+11.
